// File: rtl/serial_add_ctrl_pkg.sv
// rtl/serial_add_ctrl_pkg.sv - shared types and constants for the bit-serial adder sequencer
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement subtract: a + ~b + 1
  localparam logic SUB_CARRY_INIT = 1'b1;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - link between the sequencer and the external 1-bit full adder cell
interface serial_add_ctrl_if;

  logic fa_a;
  logic fa_b;
  logic fa_cin;
  logic fa_s;
  logic fa_cout;

  modport master (
    output fa_a,
    output fa_b,
    output fa_cin,
    input  fa_s,
    input  fa_cout
  );

  modport slave (
    input  fa_a,
    input  fa_b,
    input  fa_cin,
    output fa_s,
    output fa_cout
  );

endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - feeds one full adder cell LSB first to add or subtract WIDTH-bit operands
import serial_add_pkg::*;

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sub,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  serial_add_ctrl_if.master  fa,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   sum,
  output logic               cout,
  output logic               ovf
);

  localparam int AW = WIDTH - 1;

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [AW-1:0]    acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last_bit;

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub ? SUB_CARRY_INIT : cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          // acc keeps the low WIDTH-1 sum bits; the MSB arrives on the final edge
          acc   <= AW'({fa.fa_s, acc} >> 1);
          carry <= fa.fa_cout;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + CNT_W'(1);
          if (last_bit) begin
            sum  <= {fa.fa_s, acc};
            cout <= fa.fa_cout;
            ovf  <= carry ^ fa.fa_cout;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    fa.fa_a   = 1'b0;
    fa.fa_b   = 1'b0;
    fa.fa_cin = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = RUN;
      end
      RUN: begin
        busy      = 1'b1;
        fa.fa_a   = a_sh[0];
        fa.fa_b   = b_sh[0];
        fa.fa_cin = carry;
        if (last_bit) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed scoreboard bench for serial_add_ctrl with a full adder on fa_*
module tb_serial_add_ctrl;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;

  int n_checks;
  int n_pass;
  exp_t sb[$];

  serial_add_ctrl_if fa_if ();

  assign fa_if.fa_s    = fa_if.fa_a ^ fa_if.fa_b ^ fa_if.fa_cin;
  assign fa_if.fa_cout = (fa_if.fa_a & fa_if.fa_b) | (fa_if.fa_cin & (fa_if.fa_a ^ fa_if.fa_b));

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .fa    (fa_if.master),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic s_i, input logic [7:0] a_i,
                                 input logic [7:0] b_i, input logic c_i);
    logic [8:0] t;
    logic [7:0] bb;
    exp_t       e;
    bb     = s_i ? ~b_i : b_i;
    t      = {1'b0, a_i} + {1'b0, bb} + {8'd0, (s_i ? 1'b1 : c_i)};
    e.sum  = t[7:0];
    e.cout = t[8];
    e.ovf  = (a_i[7] == bb[7]) && (t[7] != a_i[7]);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // n counts edges from the accepting edge (n=1); done is expected after the 9th
  task automatic run_op(input string tag, input logic s_i, input logic [7:0] a_i,
                        input logic [7:0] b_i, input logic c_i, input bit mid_start);
    int   busy_cnt;
    int   dones;
    int   done_at;
    exp_t e;
    sub   = s_i;
    a     = a_i;
    b     = b_i;
    cin   = c_i;
    start = 1'b1;
    sb.push_back(model(s_i, a_i, b_i, c_i));
    tick();
    start = 1'b0;
    check({tag, " fa_cin first RUN"}, {31'd0, fa_if.fa_cin}, {31'd0, (s_i ? 1'b1 : c_i)});
    busy_cnt = 0;
    dones    = 0;
    done_at  = 0;
    for (int n = 1; n <= 12; n++) begin
      if (busy) busy_cnt++;
      if (done) begin
        dones++;
        if (done_at == 0) done_at = n;
      end
      if (mid_start && n == 3) begin
        start = 1'b1;
        sub   = ~s_i;
        a     = ~a_i;
        b     = 8'h55;
        cin   = ~c_i;
      end
      if (n == 4) start = 1'b0;
      if (n < 12) tick();
    end
    check({tag, " done edge"}, done_at, 9);
    check({tag, " done pulses"}, dones, 1);
    check({tag, " busy cycles"}, busy_cnt, 9);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " sum"}, {24'd0, sum}, {24'd0, e.sum});
      check({tag, " cout"}, {31'd0, cout}, {31'd0, e.cout});
      check({tag, " ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
    end else begin
      check({tag, " scoreboard empty"}, 1, 0);
    end
  endtask

  initial begin
    int dones;
    n_checks = 0;
    n_pass   = 0;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    cin   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset busy", {31'd0, busy}, 0);
    check("reset done", {31'd0, done}, 0);
    check("reset sum", {24'd0, sum}, 0);
    check("reset cout/ovf", {30'd0, cout, ovf}, 0);
    check("reset fa", {29'd0, fa_if.fa_a, fa_if.fa_b, fa_if.fa_cin}, 0);

    run_op("add 05+03", 1'b0, 8'h05, 8'h03, 1'b0, 1'b0);
    check("idle fa", {29'd0, fa_if.fa_a, fa_if.fa_b, fa_if.fa_cin}, 0);
    run_op("add FF+01", 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op("add 7F+01", 1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
    run_op("add 80+80+1", 1'b0, 8'h80, 8'h80, 1'b1, 1'b0);
    run_op("sub 05-07", 1'b1, 8'h05, 8'h07, 1'b1, 1'b0);
    run_op("sub 80-01", 1'b1, 8'h80, 8'h01, 1'b0, 1'b0);
    run_op("busy start 3C+5A", 1'b0, 8'h3C, 8'h5A, 1'b0, 1'b1);

    // abort in the 4th RUN cycle
    sub   = 1'b0;
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", {31'd0, busy}, 0);
    check("abort sum", {24'd0, sum}, 0);
    check("abort cout/ovf", {30'd0, cout, ovf}, 0);
    check("abort fa", {29'd0, fa_if.fa_a, fa_if.fa_b, fa_if.fa_cin}, 0);
    dones = 0;
    for (int n = 0; n < 12; n++) begin
      if (done) dones++;
      tick();
    end
    check("abort no done", dones, 0);

    run_op("post-abort 05+03", 1'b0, 8'h05, 8'h03, 1'b0, 1'b0);
    check("scoreboard drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
